// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run-controlled divider with ratios /2, /4, /8 and /16.
// A new ratio is requested over a four-phase sel_req/sel_ack handshake.
// Ratio changes and stops are applied only at the end of a divided period,
// so div_clk never shows a phase shorter than half the ratio in force.
// div_clk and tick are registered. Both are computed from next-state values,
// so they are high in the same cycles as count[sel_cur] and count==N-1.
module clk_div_ctrl #(
   parameter int CNT_W = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic [1:0] sel_in,
   input  logic       sel_req,
   output logic       sel_ack,
   output logic       busy,
   output logic [1:0] sel_cur,
   output logic       div_clk,
   output logic       tick
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W:0]   SPAN_ONE = (CNT_W + 1)'(1);

   // Limit a ratio code so that it never selects a bit above the counter MSB.
   function automatic logic [1:0] clamp_code(input logic [1:0] code);
      if (int'(code) > (CNT_W - 1)) begin
         return 2'(CNT_W - 1);
      end else begin
         return code;
      end
   endfunction

   // Terminal count N-1 for a ratio code, where N = 2^(code+1).
   function automatic logic [CNT_W-1:0] last_cnt(input logic [1:0] code);
      logic [CNT_W:0] span;
      span = SPAN_ONE << ({1'b0, clamp_code(code)} + 3'd1);
      span = span - SPAN_ONE;
      return span[CNT_W-1:0];
   endfunction

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [1:0]       sel_cur_r;
   logic [1:0]       sel_cur_nxt_s;
   logic [1:0]       sel_nxt_r;
   logic [1:0]       sel_nxt_nxt_s;
   logic             busy_r;
   logic             busy_nxt_s;
   logic             ack_r;
   logic             ack_nxt_s;
   logic             div_r;
   logic             div_nxt_s;
   logic             tick_r;
   logic             tick_nxt_s;
   logic             boundary_s;
   logic             apply_s;
   logic             capture_s;

   // Decode period boundary, ratio apply and request capture from registers.
   always_comb begin
      boundary_s = (state_r == ST_RUN) && (cnt_r == last_cnt(sel_cur_r));
      apply_s    = busy_r && ((state_r == ST_IDLE) || boundary_s);
      capture_s  = sel_req && !ack_r && !busy_r;
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next state: start on run; stop only at a period boundary.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (run) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (boundary_s && !run) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Next values for the counter, the ratio handshake and the registered outputs.
   always_comb begin
      cnt_nxt_s     = CNT_ZERO;
      sel_cur_nxt_s = sel_cur_r;
      sel_nxt_nxt_s = sel_nxt_r;
      busy_nxt_s    = busy_r;
      ack_nxt_s     = ack_r;

      if ((state_r == ST_RUN) && !boundary_s) begin
         cnt_nxt_s = cnt_r + CNT_ONE;
      end else begin
         cnt_nxt_s = CNT_ZERO;
      end

      if (apply_s) begin
         sel_cur_nxt_s = sel_nxt_r;
         busy_nxt_s    = 1'b0;
         ack_nxt_s     = 1'b1;
      end else if (capture_s) begin
         sel_nxt_nxt_s = clamp_code(sel_in);
         busy_nxt_s    = 1'b1;
         ack_nxt_s     = ack_r;
      end else if (!sel_req) begin
         ack_nxt_s     = 1'b0;
      end else begin
         ack_nxt_s     = ack_r;
      end

      if (state_nxt_s == ST_RUN) begin
         div_nxt_s  = cnt_nxt_s[clamp_code(sel_cur_nxt_s)];
         tick_nxt_s = (cnt_nxt_s == last_cnt(sel_cur_nxt_s));
      end else begin
         div_nxt_s  = 1'b0;
         tick_nxt_s = 1'b0;
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r     <= CNT_ZERO;
         sel_cur_r <= 2'd0;
         sel_nxt_r <= 2'd0;
         busy_r    <= 1'b0;
         ack_r     <= 1'b0;
         div_r     <= 1'b0;
         tick_r    <= 1'b0;
      end else begin
         cnt_r     <= cnt_nxt_s;
         sel_cur_r <= sel_cur_nxt_s;
         sel_nxt_r <= sel_nxt_nxt_s;
         busy_r    <= busy_nxt_s;
         ack_r     <= ack_nxt_s;
         div_r     <= div_nxt_s;
         tick_r    <= tick_nxt_s;
      end
   end

   assign sel_ack = ack_r;
   assign busy    = busy_r;
   assign sel_cur = sel_cur_r;
   assign div_clk = div_r;
   assign tick    = tick_r;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Testbench for clk_div_ctrl.
// Each vector holds the inputs applied before a clock edge and the outputs
// expected after that edge. Vectors go through a scoreboard queue.
module tb_clk_div_ctrl;

   typedef struct {
      logic       run;
      logic [1:0] sel_in;
      logic       req;
      logic       div;
      logic       tick;
      logic       busy;
      logic       ack;
      logic [1:0] sel;
   } vec_t;

   logic       clk;
   logic       rst;
   logic       run;
   logic [1:0] sel_in;
   logic       sel_req;
   logic       sel_ack;
   logic       busy;
   logic [1:0] sel_cur;
   logic       div_clk;
   logic       tick;

   int   total;
   int   passed;
   int   step_no;
   vec_t tbl[$];
   vec_t exp_q[$];

   clk_div_ctrl #(.CNT_W(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .run     (run),
      .sel_in  (sel_in),
      .sel_req (sel_req),
      .sel_ack (sel_ack),
      .busy    (busy),
      .sel_cur (sel_cur),
      .div_clk (div_clk),
      .tick    (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic r, input logic [1:0] si, input logic q,
                               input logic d, input logic t, input logic b,
                               input logic a, input logic [1:0] s);
      vec_t v;
      v.run = r; v.sel_in = si; v.req = q;
      v.div = d; v.tick = t; v.busy = b; v.ack = a; v.sel = s;
      return v;
   endfunction

   task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
      total++;
      if (act !== exp) begin
         $display("FAIL %s step %0d: got %0d expected %0d", name, step_no, act, exp);
      end else begin
         passed++;
      end
   endtask

   task automatic chk_all(input vec_t e);
      chk("div_clk", {1'b0, div_clk}, {1'b0, e.div});
      chk("tick",    {1'b0, tick},    {1'b0, e.tick});
      chk("busy",    {1'b0, busy},    {1'b0, e.busy});
      chk("sel_ack", {1'b0, sel_ack}, {1'b0, e.ack});
      chk("sel_cur", sel_cur,         e.sel);
   endtask

   // Drive one vector, queue its expectation, then compare after the edge.
   task automatic apply_vec(input vec_t v);
      vec_t e;
      run     = v.run;
      sel_in  = v.sel_in;
      sel_req = v.req;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      step_no++;
      chk_all(e);
   endtask

   initial begin
      total = 0; passed = 0; step_no = 0;
      rst = 1'b0; run = 1'b0; sel_in = 2'd0; sel_req = 1'b0;

      // Table: start at /2, change to /16 at count 0, one full /16 period.
      tbl.push_back(mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0)); // count 0
      tbl.push_back(mk(1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0)); // count 1
      tbl.push_back(mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
      tbl.push_back(mk(1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0));
      tbl.push_back(mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0)); // count 0
      tbl.push_back(mk(1'b1, 2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0)); // capture
      tbl.push_back(mk(1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3)); // apply
      tbl.push_back(mk(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3)); // count 1, ack clear
      for (int c = 2; c < 16; c++) begin
         tbl.push_back(mk(1'b1, 2'd0, 1'b0, c >= 8, c == 15, 1'b0, 1'b0, 2'd3));
      end
      tbl.push_back(mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3)); // count 0

      #12;
      step_no = 0;
      chk_all(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         apply_vec(tbl[i]);
      end

      // /16 -> /8: a second request while busy is ignored, ack is held while req is held.
      for (int c = 1; c < 16; c++) begin
         apply_vec(mk(1'b1, (c <= 5) ? 2'd2 : 2'd1, (c == 5) ? 1'b0 : 1'b1,
                      c >= 8, c == 15, 1'b1, 1'b0, 2'd3));
      end
      apply_vec(mk(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2)); // apply first request
      apply_vec(mk(1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2)); // no re-capture
      apply_vec(mk(1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2)); // count 2, ack clear
      // Stop at /8 from count 2: five more RUN cycles, one tick, then IDLE.
      for (int c = 3; c < 8; c++) begin
         apply_vec(mk(1'b0, 2'd0, 1'b0, c >= 4, c == 7, 1'b0, 1'b0, 2'd2));
      end
      for (int i = 0; i < 3; i++) begin
         apply_vec(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2));
      end

      // Change to /4 while IDLE: ack two edges after the request is sampled.
      apply_vec(mk(1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2));
      apply_vec(mk(1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1));
      apply_vec(mk(1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1));
      // Run at /4; stop and change to /8 land on the same boundary.
      apply_vec(mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1)); // count 0
      apply_vec(mk(1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1)); // count 1
      apply_vec(mk(1'b1, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1)); // count 2
      apply_vec(mk(1'b0, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1)); // count 3
      apply_vec(mk(1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2)); // IDLE + apply
      apply_vec(mk(1'b0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2));
      // Restart at /8 from count 0.
      apply_vec(mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2));
      for (int c = 1; c < 8; c++) begin
         apply_vec(mk(1'b1, 2'd0, 1'b0, c >= 4, c == 7, 1'b0, 1'b0, 2'd2));
      end
      apply_vec(mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2));

      // Move to /16, then raise a request and stop at count 11 with busy set.
      apply_vec(mk(1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2));
      for (int c = 2; c < 8; c++) begin
         apply_vec(mk(1'b1, 2'd3, 1'b1, c >= 4, c == 7, 1'b1, 1'b0, 2'd2));
      end
      apply_vec(mk(1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3));
      apply_vec(mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3));
      for (int c = 2; c < 12; c++) begin
         apply_vec(mk(1'b1, 2'd0, 1'b1, c >= 8, 1'b0, 1'b1, 1'b0, 2'd3));
      end

      // Asynchronous reset between clock edges clears everything at once.
      rst = 1'b0; run = 1'b0; sel_req = 1'b0; sel_in = 2'd0;
      #1;
      step_no++;
      chk_all(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      apply_vec(mk(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
      apply_vec(mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
      apply_vec(mk(1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0));
      apply_vec(mk(1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Run-controlled, ratio-selectable clock divider with a four-phase handshake for ratio changes. Ratio changes and stop requests take effect only at a divided-period boundary, so `div_clk` never produces a runt phase. The block sits between configuration logic and the divided-clock consumers, and replaces fixed /2, /4, /8, /16 tap usage with one managed output plus a period tick.

## Interface
- `CNT_W`, default 4: period counter width. The maximum ratio is 2^CNT_W; the ratio code width is fixed at 2 bits for the default.
- `clk`  in  1  system clock; all state is updated on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; 1 = divide, 0 = stop at the next period boundary.
- `sel_in`  in  2  requested ratio code: 0→/2, 1→/4, 2→/8, 3→/16 (N = 2^(code+1)).
- `sel_req`  in  1  four-phase request; `sel_in` must be held stable while `sel_req`=1.
- `sel_ack`  out  1  four-phase acknowledge; asserts when the new ratio is applied.
- `busy`  out  1  a captured ratio change is pending.
- `sel_cur`  out  2  ratio code currently in force.
- `div_clk`  out  1  registered divided clock, 50% duty.
- `tick`  out  1  high for the last `clk` cycle of each divided period while running.

## Operation
- FSM with two states:
  - **IDLE**: counter held at 0, `div_clk`=0.
  - **RUN**: counter increments by 1 each edge, modulo N of `sel_cur`.
- IDLE→RUN on an edge with `run`=1. The counter stays 0 on that edge, so the first RUN cycle has count 0.
- **Boundary** = RUN with count == N−1. On that edge the counter loads 0, and:
  - If `run`=0: go to IDLE; `div_clk` loads 0.
  - If `busy`=1: load `sel_cur`←`sel_nxt`, clear `busy`, set `sel_ack`.
  - Stop and ratio apply may occur on the same edge.
- `run`=0 outside a boundary has no effect until the boundary; the current period always completes.
- `run` rising again during that wind-down keeps RUN with no interruption.
- In IDLE, a pending change applies on the next edge: `sel_cur` update, `busy` clear, `sel_ack` set.
- **Request capture**: on an edge with `sel_req`=1, `sel_ack`=0 and `busy`=0:
  - `sel_nxt`←`sel_in`, `busy`←1.
  - A capture edge is never also the apply edge; the earliest apply is the next boundary, or the next edge in IDLE.
- `sel_ack` clears on the first edge with `sel_req`=0.
- A new request is recognised only after `sel_ack` has returned to 0.
- A request for a code equal to `sel_cur` still completes the full handshake.
- `div_clk` register loads bit `sel` of the next count, so `div_clk` == count[`sel_cur`] in RUN: low for N/2 cycles, then high for N/2.
- `tick` = (state==RUN) & (count==N−1), decoded from registers only.
- Counter width is CNT_W. Ratio codes above CNT_W−1 are clamped to CNT_W−1.

## Timing
- Reset (async assert, any time, including mid-period or mid-handshake): state IDLE, count 0, `sel_cur`=0, `sel_nxt`=0, `div_clk`=0, `tick`=0, `busy`=0, `sel_ack`=0.
- Reset deassertion is synchronised externally.
- Start latency: `run` sampled high at edge k gives count 0 after edge k. `div_clk` first rises after edge k+N/2.
- Stop latency: at most N−1 cycles after `run` falls; `div_clk` ends low.
- Change latency in RUN: capture edge, then at most N edges to apply. `sel_ack` is visible in the cycle after apply.
- Change latency in IDLE: `sel_ack` is high 2 edges after `sel_req` is sampled.
- Steady state: exactly one `tick` per N cycles; `div_clk` period is exactly N cycles; no phase is shorter than N/2 of the ratio in force.

## Test plan
- **Reset, then start at /2**: `rst` low→high, `run`=1 → `div_clk` 0,1,0,1…; `tick` high on each count-1 cycle; `sel_cur`=0; `busy`=0.
- **Change /2→/16 mid-period**: change captured at count 0 → `busy`=1 for one cycle, apply at the next boundary, `sel_ack` high. Then `div_clk` shows 8 low / 8 high, with `tick` every 16 cycles.
- **Stop from /8 at count 2**: `run` dropped at count 2 → 5 more cycles in RUN; `tick` once at count 7; then IDLE with `div_clk`=0 and no further ticks.
- **Simultaneous events**: at /4, `run`=0 while a change to /8 is pending, boundary reached → both applied on one edge. Restart then runs at /8 from count 0.
- **Handshake protocol**:
  - `sel_req` held high after `sel_ack` → no re-capture; `sel_ack` stays 1.
  - `sel_req` dropped → `sel_ack` clears next edge.
  - A second request while `busy`=1 is ignored until the first completes.
- **Async reset mid-operation**: `rst` pulsed low at /16, count 11, `busy`=1 → all outputs clear without waiting for a `clk` edge; `sel_cur`=0 after release.
